fairy_wb_stage: RTL

//  Writeback stage of the fairy 5-stage MIPS pipeline, directly downstream of the memory stage.
//  - Registers the memory-stage outputs and drives the register-file write port.
//  - Holds the HI/LO registers and a minimal CP0 (Status, Cause, EPC, BadVAddr).
//  - Detects precise exceptions and ERET, flushes younger stages and redirects fetch.

---
 rtl/fairy_defs_pkg.sv | 59 +++++
 rtl/fairy_wb_stage_cp0.sv | 69 ++++++
 rtl/fairy_wb_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fairy_defs_pkg.sv
// Shared definitions for the fairy writeback stage: exception codes,
// CP0 register numbers, opcode classes and the pipeline register layout.
package fairy_defs;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LWL  = 6'b100010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LWR  = 6'b100110;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SWL  = 6'b101010;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SWR  = 6'b101110;
  localparam logic [5:0] OP_COP0 = 6'b010000;

  localparam logic [4:0]  RS_MFC0   = 5'b00000;
  localparam logic [4:0]  RS_MTC0   = 5'b00100;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef enum logic {ST_RUN, ST_FLUSH} wb_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  reg_waddr;
    logic        reg_we;
    logic        delayslot;
    logic        overflow;
    logic        unaligned;
    logic        illegal;
    logic        hilo_we;
    logic        hilo_sel;
  } wb_reg_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW) ||
           (op == OP_SWR);
  endfunction

endpackage

// File: rtl/fairy_wb_stage_cp0.sv
// Minimal CP0: Status, Cause, EPC and BadVAddr with MTC0 write,
// MFC0 read mux and exception / ERET side effects.
module fairy_cp0_regs
  import fairy_defs::*;
#(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_we,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic        bad_we,
  input  logic [31:0] bad_val,
  input  logic        eret_we,
  input  logic        mtc0_we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc_o
);

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;

  // Exceptions take precedence over ERET, which takes precedence over MTC0.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= RESET_STATUS;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else if (exc_we) begin
      cause_q[31]  <= exc_bd;
      cause_q[6:2] <= exc_code;
      // A nested exception keeps the EPC of the first one.
      if (!status_q[1]) epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      status_q[1] <= 1'b1;
      if (bad_we) badvaddr_q <= bad_val;
    end else if (eret_we) begin
      status_q[1] <= 1'b0;
    end else if (mtc0_we) begin
      case (addr)
        CP0_STATUS: status_q     <= wdata;
        CP0_CAUSE:  cause_q[9:8] <= wdata[9:8];
        CP0_EPC:    epc_q        <= wdata;
        default:    ;
      endcase
    end
  end

  // MFC0 read mux; unimplemented register numbers read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause_q;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign epc_o = epc_q;

endmodule

// File: rtl/fairy_wb_stage.sv
// Writeback stage of the fairy pipeline: pipeline register, precise
// exception detection, ERET handling, HI/LO and fetch redirect.
// Optional trace outputs are built when FAIRY_WB_DEBUG_EN is defined.
module fairy_wb_stage
  import fairy_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic        delayslot_i,
  input  logic        overflow_i,
  input  logic        unaligned_addr_i,
  input  logic        illegal_inst_i,
  input  logic        hilo_we_i,
  input  logic        hilo_sel_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        exception_o,
  output logic        eret_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  wb_reg_t     wb_q;
  wb_state_e   state_q;
  logic [31:0] hi_q, lo_q;
  logic        exc_any, bad_we;
  logic [4:0]  exc_code;
  logic [31:0] bad_val, cp0_rdata, epc;
  logic [5:0]  op;
  logic        is_cop0, is_mtc0, is_mfc0, mem_ld, mem_st;

  assign op      = wb_q.inst[31:26];
  assign is_cop0 = (op == OP_COP0);
  assign is_mtc0 = is_cop0 && (wb_q.inst[25:21] == RS_MTC0);
  assign is_mfc0 = is_cop0 && (wb_q.inst[25:21] == RS_MFC0);
  assign mem_ld  = is_load(op);
  assign mem_st  = is_store(op);

  // Input capture; an outgoing flush replaces the next instruction with a bubble.
  always_ff @(posedge clk) begin
    if (reset || exception_o || eret_o) begin
      wb_q <= '0;
    end else begin
      wb_q <= '{inst: inst_i, pc: pc_i, data: data_i, reg_waddr: reg_waddr_i,
                reg_we: reg_we_i, delayslot: delayslot_i, overflow: overflow_i,
                unaligned: unaligned_addr_i, illegal: illegal_inst_i,
                hilo_we: hilo_we_i, hilo_sel: hilo_sel_i};
    end
  end

  // Exception priority encoder over the registered instruction.
  always_comb begin
    exc_any  = 1'b0;
    exc_code = '0;
    bad_we   = 1'b0;
    bad_val  = '0;
    if (state_q == ST_RUN) begin
      if (wb_q.unaligned && !mem_ld && !mem_st) begin
        exc_any = 1'b1; exc_code = EXC_ADEL; bad_we = 1'b1; bad_val = wb_q.pc;
      end else if (wb_q.illegal) begin
        exc_any = 1'b1; exc_code = EXC_RI;
      end else if (wb_q.overflow) begin
        exc_any = 1'b1; exc_code = EXC_OV;
      end else if (wb_q.unaligned && mem_ld) begin
        exc_any = 1'b1; exc_code = EXC_ADEL; bad_we = 1'b1; bad_val = wb_q.data;
      end else if (wb_q.unaligned && mem_st) begin
        exc_any = 1'b1; exc_code = EXC_ADES; bad_we = 1'b1; bad_val = wb_q.data;
      end
    end
  end

  assign exception_o = exc_any;
  assign eret_o      = (state_q == ST_RUN) && !exc_any && (wb_q.inst == ERET_WORD);

  fairy_cp0_regs #(.RESET_STATUS(RESET_STATUS)) u_cp0 (
    .clk      (clk),
    .reset    (reset),
    .exc_we   (exc_any),
    .exc_code (exc_code),
    .exc_bd   (wb_q.delayslot),
    .exc_pc   (wb_q.pc),
    .bad_we   (bad_we),
    .bad_val  (bad_val),
    .eret_we  (eret_o),
    .mtc0_we  (is_mtc0 && !exc_any),
    .addr     (wb_q.inst[15:11]),
    .wdata    (wb_q.data),
    .rdata    (cp0_rdata),
    .epc_o    (epc)
  );

  // Flush sequencer: one redirect cycle after each exception or ERET.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_any) begin
            state_q       <= ST_FLUSH;
            redirect_o    <= 1'b1;
            redirect_pc_o <= EXC_VECTOR;
          end else if (eret_o) begin
            state_q       <= ST_FLUSH;
            redirect_o    <= 1'b1;
            redirect_pc_o <= epc;
          end else begin
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
          end
        end
        default: begin
          state_q       <= ST_RUN;
          redirect_o    <= 1'b0;
          redirect_pc_o <= '0;
        end
      endcase
    end
  end

  // HI/LO update, dropped when the instruction faults.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_q.hilo_we && !exc_any) begin
      if (wb_q.hilo_sel) hi_q <= wb_q.data;
      else               lo_q <= wb_q.data;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign rf_we_o    = wb_q.reg_we && !exc_any && (wb_q.reg_waddr != 5'd0);
  assign rf_waddr_o = wb_q.reg_waddr;
  assign rf_wdata_o = is_mfc0 ? cp0_rdata : wb_q.data;

`ifdef FAIRY_WB_DEBUG_EN
  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we_o}};
  assign debug_wb_rf_wnum  = rf_waddr_o;
  assign debug_wb_rf_wdata = rf_wdata_o;
`else
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule
